// File: rtl/ahb_mtx_pkg.sv
// ahb_mtx_pkg
//   Shared AHB encodings for the bus-matrix output-stage logic.
//   htrans_e / hburst_e : AMBA AHB transfer-type and burst-type codes.
//   burst_len_m1()      : number of beats left after the first beat of a
//                         fixed-length burst. SINGLE and INCR return 0
//                         because their length is not known in advance.
package ahb_mtx_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'd0,
      HBURST_INCR   = 3'd1,
      HBURST_WRAP4  = 3'd2,
      HBURST_INCR4  = 3'd3,
      HBURST_WRAP8  = 3'd4,
      HBURST_INCR8  = 3'd5,
      HBURST_WRAP16 = 3'd6,
      HBURST_INCR16 = 3'd7
   } hburst_e;

   function automatic logic [3:0] burst_len_m1(input logic [2:0] hburst);
      logic [3:0] len_m1;
      case (hburst_e'(hburst))
         HBURST_WRAP4,  HBURST_INCR4:  len_m1 = 4'd3;
         HBURST_WRAP8,  HBURST_INCR8:  len_m1 = 4'd7;
         HBURST_WRAP16, HBURST_INCR16: len_m1 = 4'd15;
         default:                      len_m1 = 4'd0;
      endcase
      return len_m1;
   endfunction

endpackage

// File: rtl/ahb_mtx_rr_pick.sv
// ahb_mtx_rr_pick
//   Combinational round-robin picker. The search starts at last_grant+1 and
//   wraps, so the most recently granted port has the lowest priority.
//   eligible   in  NUM_PORTS  ports that may be granted
//   last_grant in  SEL_W      port granted by the previous arbitration
//   winner     out SEL_W      selected port (0 when nothing is eligible)
//   any_valid  out 1          at least one port is eligible
module ahb_mtx_rr_pick #(
   parameter int NUM_PORTS = 4,
   parameter int SEL_W     = 3
) (
   input  logic [NUM_PORTS-1:0] eligible,
   input  logic [SEL_W-1:0]     last_grant,
   output logic [SEL_W-1:0]     winner,
   output logic                 any_valid
);

   localparam int unsigned NP = NUM_PORTS;

   // Distance of port p from the search start (last_grant+1), modulo NP.
   // The caller keeps last_grant below NP, so the sum stays in [0, 2*NP).
   function automatic int unsigned rr_dist(input int unsigned p, input int unsigned lg);
      int unsigned d;
      d = p + NP - 1 - lg;
      if (d >= NP) d = d - NP;
      return d;
   endfunction

   int unsigned best_d;

   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      best_d    = NP;
      for (int unsigned p = 0; p < NP; p++) begin
         if (eligible[p] && (rr_dist(p, 32'(last_grant)) < best_d)) begin
            best_d    = rr_dist(p, 32'(last_grant));
            winner    = SEL_W'(p);
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_mtx_arb_rr_burst.sv
// ahb_mtx_arb_rr_burst
//   Round-robin output-stage arbiter for one AHB bus-matrix slave port. The
//   grant is held for locked sequences and for the remaining beats of
//   fixed-length bursts.
//   HCLK, HRESETn       clock, asynchronous active-low reset
//   req_port            per-input-port request for this output
//   HREADYM             output transfer done; all state advances only when 1
//   HSELM/HTRANSM/
//   HBURSTM/HMASTLOCKM  transfer currently driven on the output
//   addr_in_port        selected input port (registered)
//   no_port             no input port selected (registered)
//   burst_hold          grant held by the burst/lock rule (combinational)
module ahb_mtx_arb_rr_burst
   import ahb_mtx_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int SEL_W     = 3
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic [NUM_PORTS-1:0] req_port,
   input  logic                 HREADYM,
   input  logic                 HSELM,
   input  logic [1:0]           HTRANSM,
   input  logic [2:0]           HBURSTM,
   input  logic                 HMASTLOCKM,
   output logic [SEL_W-1:0]     addr_in_port,
   output logic                 no_port,
   output logic                 burst_hold
);

   logic [SEL_W-1:0]     addr_in_port_q, addr_in_port_d;
   logic                 no_port_q, no_port_d;
   logic [SEL_W-1:0]     last_grant_q, last_grant_d;
   logic [3:0]           beat_cnt_q, beat_cnt_d;
   logic [3:0]           rem_now;
   logic                 cur_active;
   logic [NUM_PORTS-1:0] eligible;
   logic [SEL_W-1:0]     rr_winner;
   logic                 rr_any;

   // Beats still owed after the transfer on the output now. A NONSEQ reloads
   // from the burst type and IDLE clears, so an early-terminated burst leaves
   // no stale hold behind.
   always_comb begin
      rem_now = '0;
      if (HSELM) begin
         case (htrans_e'(HTRANSM))
            HTRANS_NONSEQ: rem_now = burst_len_m1(HBURSTM);
            HTRANS_SEQ:    rem_now = (beat_cnt_q == '0) ? '0 : beat_cnt_q - 4'd1;
            HTRANS_BUSY:   rem_now = beat_cnt_q;
            default:       rem_now = '0;
         endcase
      end
   end

   assign burst_hold = HMASTLOCKM | (HSELM & (rem_now != '0));

   // The port owning the live transfer stays eligible even if its request
   // has already dropped, so it can compete for the next beat.
   assign cur_active = HSELM & (HTRANSM != HTRANS_IDLE);

   always_comb begin
      eligible = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         eligible[p] = req_port[p] | (cur_active & (addr_in_port_q == SEL_W'(p)));
      end
   end

   ahb_mtx_rr_pick #(
      .NUM_PORTS (NUM_PORTS),
      .SEL_W     (SEL_W)
   ) u_rr_pick (
      .eligible   (eligible),
      .last_grant (last_grant_q),
      .winner     (rr_winner),
      .any_valid  (rr_any)
   );

   always_comb begin
      addr_in_port_d = addr_in_port_q;
      no_port_d      = no_port_q;
      last_grant_d   = last_grant_q;
      beat_cnt_d     = beat_cnt_q;
      if (HREADYM) begin
         beat_cnt_d = rem_now;
         if (burst_hold) begin
            no_port_d = 1'b0;
         end else if (rr_any) begin
            addr_in_port_d = rr_winner;
            last_grant_d   = rr_winner;
            no_port_d      = 1'b0;
         end else begin
            no_port_d = ~HSELM;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_in_port_q <= '0;
         no_port_q      <= 1'b1;
         last_grant_q   <= SEL_W'(NUM_PORTS - 1);
         beat_cnt_q     <= '0;
      end else begin
         addr_in_port_q <= addr_in_port_d;
         no_port_q      <= no_port_d;
         last_grant_q   <= last_grant_d;
         beat_cnt_q     <= beat_cnt_d;
      end
   end

   assign addr_in_port = addr_in_port_q;
   assign no_port      = no_port_q;

endmodule

// File: tb/tb_ahb_mtx_arb_rr_burst.sv
// tb_ahb_mtx_arb_rr_burst
//   Directed vectors for the round-robin/burst-hold output arbiter. Each row
//   gives the inputs for one clock cycle and the outputs expected during that
//   cycle: the registered outputs from the previous edge, and burst_hold from
//   the present inputs.
module tb_ahb_mtx_arb_rr_burst;

   localparam int NP = 4;
   localparam int SW = 3;

   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NSEQ = 2'd2, SEQ = 2'd3;
   localparam logic [2:0] SINGLE = 3'd0, WRAP8 = 3'd4, INCR4 = 3'd3,
                          INCR8 = 3'd5, INCR16 = 3'd7;

   logic          HCLK = 1'b0;
   logic          HRESETn;
   logic [NP-1:0] req_port;
   logic          HREADYM, HSELM, HMASTLOCKM;
   logic [1:0]    HTRANSM;
   logic [2:0]    HBURSTM;
   logic [SW-1:0] addr_in_port;
   logic          no_port, burst_hold;

   ahb_mtx_arb_rr_burst #(
      .NUM_PORTS (NP),
      .SEL_W     (SW)
   ) dut (
      .HCLK         (HCLK),
      .HRESETn      (HRESETn),
      .req_port     (req_port),
      .HREADYM      (HREADYM),
      .HSELM        (HSELM),
      .HTRANSM      (HTRANSM),
      .HBURSTM      (HBURSTM),
      .HMASTLOCKM   (HMASTLOCKM),
      .addr_in_port (addr_in_port),
      .no_port      (no_port),
      .burst_hold   (burst_hold)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      int            id;
      logic [SW-1:0] addr;
      logic          np;
      logic          hold;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   bit   stim_done = 1'b0;

   // Inputs change 2 time units after the rising edge; the expected record
   // for that cycle is queued at the same moment.
   task automatic v(input int id, input logic rst, input logic [NP-1:0] req,
                    input logic rdy, input logic sel, input logic [1:0] tr,
                    input logic [2:0] bu, input logic lk,
                    input logic [SW-1:0] ea, input logic enp, input logic eh);
      exp_t e;
      @(posedge HCLK);
      #2;
      HRESETn    = rst;
      req_port   = req;
      HREADYM    = rdy;
      HSELM      = sel;
      HTRANSM    = tr;
      HBURSTM    = bu;
      HMASTLOCKM = lk;
      e.id   = id;
      e.addr = ea;
      e.np   = enp;
      e.hold = eh;
      exp_q.push_back(e);
   endtask

   // Monitor: on each falling edge, mid-cycle, compare against the oldest
   // queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge HCLK);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (addr_in_port !== e.addr) begin
               n_err++;
               $display("FAIL row%0d addr_in_port: got %0d expected %0d", e.id, addr_in_port, e.addr);
            end
            n_cmp++;
            if (no_port !== e.np) begin
               n_err++;
               $display("FAIL row%0d no_port: got %0b expected %0b", e.id, no_port, e.np);
            end
            n_cmp++;
            if (burst_hold !== e.hold) begin
               n_err++;
               $display("FAIL row%0d burst_hold: got %0b expected %0b", e.id, burst_hold, e.hold);
            end
         end
      end
   end

   initial begin
      HRESETn    = 1'b0;
      req_port   = '0;
      HREADYM    = 1'b1;
      HSELM      = 1'b0;
      HTRANSM    = IDLE;
      HBURSTM    = SINGLE;
      HMASTLOCKM = 1'b0;
      repeat (2) @(posedge HCLK);

      //  id rst req     rdy sel tr    bu      lk  addr np hold
      // Reset release; 0 then 2 selected, no_port 1->0->1.
      v( 1, 1, 4'b0101, 1, 0, IDLE, SINGLE, 0,  0,  1,  0);
      v( 2, 1, 4'b0100, 1, 0, IDLE, SINGLE, 0,  0,  0,  0);
      v( 3, 1, 4'b0000, 1, 0, IDLE, SINGLE, 0,  2,  0,  0);
      v( 4, 1, 4'b0000, 1, 0, IDLE, SINGLE, 0,  2,  1,  0);
      // All ports requesting: rotation continues from last grant 2.
      v( 5, 1, 4'b1111, 1, 1, IDLE, SINGLE, 0,  2,  1,  0);
      v( 6, 1, 4'b1111, 1, 1, IDLE, SINGLE, 0,  3,  0,  0);
      v( 7, 1, 4'b1111, 1, 1, IDLE, SINGLE, 0,  0,  0,  0);
      v( 8, 1, 4'b1111, 1, 1, IDLE, SINGLE, 0,  1,  0,  0);
      v( 9, 1, 4'b1111, 1, 1, IDLE, SINGLE, 0,  2,  0,  0);
      v(10, 1, 4'b0000, 1, 0, IDLE, SINGLE, 0,  3,  0,  0);
      // Port 1 INCR4 while port 0 requests; port 0 wins after beat 4.
      v(11, 1, 4'b0010, 1, 0, IDLE, SINGLE, 0,  3,  1,  0);
      v(12, 1, 4'b0011, 1, 1, NSEQ, INCR4,  0,  1,  0,  1);
      v(13, 1, 4'b0011, 1, 1, SEQ,  INCR4,  0,  1,  0,  1);
      v(14, 1, 4'b0011, 1, 1, SEQ,  INCR4,  0,  1,  0,  1);
      v(15, 1, 4'b0011, 1, 1, SEQ,  INCR4,  0,  1,  0,  0);
      v(16, 1, 4'b0001, 1, 1, NSEQ, SINGLE, 0,  0,  0,  0);
      // Port 2 WRAP8 with stalls and a BUSY beat; port 0 waiting.
      v(17, 1, 4'b0100, 1, 0, IDLE, SINGLE, 0,  0,  0,  0);
      v(18, 1, 4'b0101, 1, 1, NSEQ, WRAP8,  0,  2,  0,  1);
      v(19, 1, 4'b0101, 0, 1, SEQ,  WRAP8,  0,  2,  0,  1);
      v(20, 1, 4'b0101, 1, 1, SEQ,  WRAP8,  0,  2,  0,  1);
      v(21, 1, 4'b0101, 1, 1, BUSY, WRAP8,  0,  2,  0,  1);
      v(22, 1, 4'b0101, 1, 1, SEQ,  WRAP8,  0,  2,  0,  1);
      v(23, 1, 4'b0101, 0, 1, SEQ,  WRAP8,  0,  2,  0,  1);
      v(24, 1, 4'b0101, 1, 1, SEQ,  WRAP8,  0,  2,  0,  1);
      v(25, 1, 4'b0101, 1, 1, SEQ,  WRAP8,  0,  2,  0,  1);
      v(26, 1, 4'b0101, 1, 1, SEQ,  WRAP8,  0,  2,  0,  1);
      v(27, 1, 4'b0101, 1, 1, SEQ,  WRAP8,  0,  2,  0,  1);
      v(28, 1, 4'b0101, 1, 1, SEQ,  WRAP8,  0,  2,  0,  0);
      // Port 0 INCR8 cut short by IDLE after 3 beats; port 3 takes over.
      v(29, 1, 4'b1001, 1, 1, NSEQ, INCR8,  0,  0,  0,  1);
      v(30, 1, 4'b1001, 1, 1, SEQ,  INCR8,  0,  0,  0,  1);
      v(31, 1, 4'b1001, 1, 1, SEQ,  INCR8,  0,  0,  0,  1);
      v(32, 1, 4'b1000, 1, 1, IDLE, INCR8,  0,  0,  0,  0);
      v(33, 1, 4'b0000, 1, 1, IDLE, SINGLE, 0,  3,  0,  0);
      v(34, 1, 4'b0000, 1, 1, IDLE, SINGLE, 0,  3,  0,  0);
      // Locked SINGLE beats from port 1, then reset mid-INCR16.
      v(35, 1, 4'b0010, 1, 0, IDLE, SINGLE, 0,  3,  0,  0);
      v(36, 1, 4'b1111, 1, 1, NSEQ, SINGLE, 1,  1,  0,  1);
      v(37, 1, 4'b1111, 1, 1, NSEQ, SINGLE, 1,  1,  0,  1);
      v(38, 1, 4'b1111, 1, 1, NSEQ, SINGLE, 1,  1,  0,  1);
      v(39, 1, 4'b1111, 1, 1, NSEQ, SINGLE, 1,  1,  0,  1);
      v(40, 1, 4'b1111, 1, 1, NSEQ, SINGLE, 1,  1,  0,  1);
      v(41, 1, 4'b1111, 1, 1, NSEQ, INCR16, 0,  1,  0,  1);
      v(42, 0, 4'b1111, 1, 1, SEQ,  INCR16, 0,  0,  1,  0);
      v(43, 1, 4'b0000, 1, 0, IDLE, SINGLE, 0,  0,  1,  0);
      v(44, 1, 4'b1000, 1, 0, IDLE, SINGLE, 0,  0,  1,  0);
      v(45, 1, 4'b0000, 1, 0, IDLE, SINGLE, 0,  3,  0,  0);

      // Let the monitor drain the queue, within a bounded number of cycles.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge HCLK);
      @(posedge HCLK);
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
      end
      stim_done = 1'b1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Absolute watchdog so the run always terminates.
   initial begin
      #20000;
      if (!stim_done) begin
         $display("FAIL watchdog: got timeout expected completion");
         $fatal(1, "watchdog expired");
      end
   end

endmodule
